bin_to_bcd_seq: RTL

Sequential binary-to-BCD converter using iterative shift-add-3 (double dabble), one shift per clock. It is the inverse of the terminal's combinational two-digit BCD-to-binary path. Numeric values from the command/arithmetic logic pass through it to become decimal digits for display and UART echo. Start/done handshake; the result is held until the next conversion completes.

---
 rtl/bin_to_bcd_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter (double dabble).
// One shift per clock. start/ready/done handshake; bcd holds the last
// result until the next conversion completes.
// Optional macro BCD_ASCII_OUT_EN adds a registered, leading-zero-blanked
// ASCII rendering of the result on the ascii port.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
`ifdef BCD_ASCII_OUT_EN
    ,
    output logic [8*DIGITS-1:0]   ascii
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [WIDTH-1:0]    shreg;
    logic [WIDTH-1:0]    next_shreg;
    logic [4*DIGITS-1:0] digits;
    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] next_digits;
    logic [CW-1:0]       count;
    logic                unused_carry;

    // The carry out of the top digit is overflow and is deliberately dropped.
    assign unused_carry = adj[4*DIGITS-1];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the ready/done handshake outputs.
    always_comb begin
        next_state = state;
        ready      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (count == CW'(1)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // One double-dabble step: add 3 to every digit >= 5, then shift the
    // digit/operand chain left by one with the operand MSB entering digit 0.
    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digits[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = digits[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = digits[4*i +: 4];
            end
        end
        next_digits = {adj[4*DIGITS-2:0], shreg[WIDTH-1]};
        next_shreg  = {shreg[WIDTH-2:0], 1'b0};
    end

`ifdef BCD_ASCII_OUT_EN
    logic [8*DIGITS-1:0] next_ascii;
    logic                blank;

    // Render the finished digits as ASCII, blanking zeros above the most
    // significant non-zero digit; the ones digit is always shown.
    always_comb begin
        next_ascii = '0;
        blank      = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (blank && (next_digits[4*k +: 4] == 4'd0)) begin
                next_ascii[8*k +: 8] = 8'h20;
            end else begin
                blank                = 1'b0;
                next_ascii[8*k +: 8] = {4'h3, next_digits[4*k +: 4]};
            end
        end
        next_ascii[7:0] = {4'h3, next_digits[3:0]};
    end
`endif

    // Datapath: load on accepted start, shift while converting, and publish
    // the result on the final shift edge so bcd is already valid while done
    // is high in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg  <= '0;
            digits <= '0;
            count  <= '0;
            bcd    <= '0;
`ifdef BCD_ASCII_OUT_EN
            ascii  <= {{(DIGITS-1){8'h20}}, 8'h30};
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg  <= bin;
                        digits <= '0;
                        count  <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    shreg  <= next_shreg;
                    digits <= next_digits;
                    count  <= count - CW'(1);
                    if (count == CW'(1)) begin
                        bcd   <= next_digits;
`ifdef BCD_ASCII_OUT_EN
                        ascii <= next_ascii;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
